// File: rtl/circuito_cl.sv
// circuito_cl: two-player chess-square recognition game.
// FSM, round/turn counters, timeout timer, scores and 7-seg debug displays.
module circuito_cl #(
    parameter int TIMEOUT = 25000,
    parameter int ROUNDS  = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [2:0] jogadaFileira,
    input  logic [2:0] jogadaColuna,
    input  logic       temJogada,
    input  logic       terminar,
    output logic [6:0] pontos1,
    output logic [6:0] pontos2,
    output logic       errou,
    output logic       db_acertou,
    output logic [6:0] linhaEsperada,
    output logic [6:0] colunaEsperada,
    output logic [6:0] db_estado
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [3:0] {
        INICIAL    = 4'h0,
        PREPARA    = 4'h1,
        ESPERA     = 4'h2,
        COMPARA    = 4'h3,
        ACERTO     = 4'h4,
        ERRO       = 4'h5,
        TIMEOUT_ST = 4'h6,
        PROXIMA    = 4'h7,
        FIM        = 4'hF
    } estado_t;

    estado_t       r_estado;
    logic [3:0]    r_rodada;
    logic [TW-1:0] r_timer;
    logic [3:0]    r_pontos1;
    logic [3:0]    r_pontos2;
    logic          r_errou;
    logic          r_acertou;
    logic          r_jog_q;

    logic          w_jogada;
    logic [2:0]    w_col;
    logic [2:0]    w_row;
    logic          w_acerto;
    logic          w_ativo;
    logic          w_ultima;
    logic          w_expirou;

    // Active-low gfedcba hex digit decoder.
    function automatic logic [6:0] hex7(input logic [3:0] d);
        case (d)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    // col = 3i+1 = i+2i+1, row = 5i = i+4i, all mod 8.
    assign w_col     = r_rodada[2:0] + {r_rodada[1:0], 1'b0} + 3'd1;
    assign w_row     = r_rodada[2:0] + {r_rodada[0], 2'b00};
    assign w_acerto  = (jogadaFileira == w_row) && (jogadaColuna == w_col);
    assign w_jogada  = temJogada & ~r_jog_q;
    assign w_ativo   = (r_estado != INICIAL) && (r_estado != FIM);
    assign w_ultima  = (r_rodada == 4'(ROUNDS - 1));
    assign w_expirou = (r_timer == TW'(TIMEOUT - 1));

    // Delayed copy of the play strobe so a held strobe counts once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_jog_q <= 1'b0;
        else       r_jog_q <= temJogada;
    end

    // Game FSM with round, timer, score and flag registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_estado  <= INICIAL;
            r_rodada  <= 4'd0;
            r_timer   <= '0;
            r_pontos1 <= 4'd0;
            r_pontos2 <= 4'd0;
            r_errou   <= 1'b0;
            r_acertou <= 1'b0;
        end else if (w_ativo && terminar) begin
            r_estado <= FIM;
        end else begin
            case (r_estado)
                INICIAL, FIM: begin
                    if (iniciar) r_estado <= PREPARA;
                end
                PREPARA: begin
                    r_rodada  <= 4'd0;
                    r_timer   <= '0;
                    r_pontos1 <= 4'd0;
                    r_pontos2 <= 4'd0;
                    r_errou   <= 1'b0;
                    r_acertou <= 1'b0;
                    r_estado  <= ESPERA;
                end
                ESPERA: begin
                    r_timer <= r_timer + 1'b1;
                    if (w_jogada)       r_estado <= COMPARA;
                    else if (w_expirou) r_estado <= TIMEOUT_ST;
                end
                COMPARA: begin
                    r_estado <= w_acerto ? ACERTO : ERRO;
                end
                ACERTO: begin
                    if (r_rodada[0]) r_pontos2 <= r_pontos2 + 4'd1;
                    else             r_pontos1 <= r_pontos1 + 4'd1;
                    r_acertou <= 1'b1;
                    r_errou   <= 1'b0;
                    r_estado  <= PROXIMA;
                end
                ERRO, TIMEOUT_ST: begin
                    r_acertou <= 1'b0;
                    r_errou   <= 1'b1;
                    r_estado  <= PROXIMA;
                end
                PROXIMA: begin
                    r_timer <= '0;
                    if (w_ultima) begin
                        r_estado <= FIM;
                    end else begin
                        r_rodada <= r_rodada + 4'd1;
                        r_estado <= ESPERA;
                    end
                end
                default: r_estado <= INICIAL;
            endcase
        end
    end

    assign pontos1        = hex7(r_pontos1);
    assign pontos2        = hex7(r_pontos2);
    assign errou          = r_errou;
    assign db_acertou     = r_acertou;
    assign db_estado      = hex7(r_estado);
    assign linhaEsperada  = w_ativo ? hex7({1'b0, w_row}) : 7'h7F;
    assign colunaEsperada = w_ativo ? hex7({1'b0, w_col}) : 7'h7F;

endmodule

// File: tb/tb_circuito_cl.sv
// Bench for circuito_cl: expected round outcomes queued at each play,
// checked when the FSM passes through PROXIMA.
module tb_circuito_cl;

    localparam int TIMEOUT = 25000;
    localparam logic [6:0] BLANK = 7'h7F;

    logic       clk = 1'b0;
    logic       rst;
    logic       iniciar = 1'b0;
    logic [2:0] fil = 3'd0;
    logic [2:0] col = 3'd0;
    logic       tem = 1'b0;
    logic       term = 1'b0;
    logic [6:0] p1, p2, lin, cole, est;
    logic       err, ac;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       ac;
        logic       er;
        logic [3:0] s1;
        logic [3:0] s2;
    } exp_t;

    exp_t sb[$];
    logic [3:0] m1, m2;
    logic prev7 = 1'b0;

    circuito_cl #(.TIMEOUT(TIMEOUT), .ROUNDS(16)) dut (
        .clock(clk), .reset(rst), .iniciar(iniciar),
        .jogadaFileira(fil), .jogadaColuna(col),
        .temJogada(tem), .terminar(term),
        .pontos1(p1), .pontos2(p2), .errou(err), .db_acertou(ac),
        .linhaEsperada(lin), .colunaEsperada(cole), .db_estado(est)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg(input int d);
        logic [6:0] t [16];
        t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return t[d & 15];
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    // Pop one expected outcome per visit to PROXIMA.
    always @(negedge clk) begin
        if (!rst && est == seg(7) && !prev7) begin
            if (sb.size() == 0) begin
                check("sb_unexpected", 32'(sb.size()), 32'd1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("acertou", 32'(ac), 32'(e.ac));
                check("errou", 32'(err), 32'(e.er));
                check("pontos1", 32'(p1), 32'(seg(e.s1)));
                check("pontos2", 32'(p2), 32'(seg(e.s2)));
            end
        end
        prev7 <= !rst && est == seg(7);
    end

    task automatic wait_st(input int code, input int budget, input string tag);
        int n = 0;
        while (est !== seg(code) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(est), 32'(seg(code)));
    endtask

    task automatic play(input logic [2:0] r, input logic [2:0] c, input int hold);
        @(posedge clk); #1;
        fil = r;
        col = c;
        tem = 1'b1;
        repeat (hold) @(posedge clk);
        #1 tem = 1'b0;
    endtask

    function automatic exp_t mk(input logic a, input logic e);
        exp_t x;
        x.ac = a; x.er = e; x.s1 = m1; x.s2 = m2;
        return x;
    endfunction

    initial begin
        rst = 1'b1;
        m1 = 0; m2 = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_estado", 32'(est), 32'(seg(0)));
        check("rst_p1", 32'(p1), 32'(seg(0)));
        check("rst_p2", 32'(p2), 32'(seg(0)));
        check("rst_errou", 32'(err), 32'd0);
        check("rst_acertou", 32'(ac), 32'd0);
        check("rst_linha", 32'(lin), 32'(BLANK));
        check("rst_coluna", 32'(cole), 32'(BLANK));

        @(posedge clk); #1 iniciar = 1'b1;
        repeat (5) @(posedge clk);
        #1 iniciar = 1'b0;
        wait_st(2, 10, "start_espera");
        check("r0_col", 32'(cole), 32'(seg(1)));
        check("r0_row", 32'(lin), 32'(seg(0)));
        repeat (1000) @(negedge clk);
        check("idle_espera", 32'(est), 32'(seg(2)));

        m1 = 1;
        sb.push_back(mk(1'b1, 1'b0));
        play(3'd0, 3'd1, 2);
        wait_st(2, 20, "r1_espera");
        check("r1_col", 32'(cole), 32'(seg(4)));
        check("r1_row", 32'(lin), 32'(seg(5)));

        sb.push_back(mk(1'b0, 1'b1));
        play(3'd1, 3'd0, 1);
        wait_st(2, 20, "r2_espera");
        check("r2_col", 32'(cole), 32'(seg(7)));
        check("r2_row", 32'(lin), 32'(seg(2)));

        sb.push_back(mk(1'b0, 1'b1));
        wait_st(7, TIMEOUT + 20, "r2_timeout");
        wait_st(2, 20, "r3_espera");
        check("r3_col", 32'(cole), 32'(seg(2)));
        check("r3_row", 32'(lin), 32'(seg(7)));

        @(posedge clk); #1 term = 1'b1;
        repeat (10) @(posedge clk);
        #1 term = 1'b0;
        @(negedge clk);
        check("fim_estado", 32'(est), 32'(seg(15)));
        check("fim_p1", 32'(p1), 32'(seg(1)));
        check("fim_p2", 32'(p2), 32'(seg(0)));
        check("fim_errou", 32'(err), 32'd1);
        check("fim_linha", 32'(lin), 32'(BLANK));

        @(posedge clk); #1 iniciar = 1'b1;
        @(posedge clk); #1 iniciar = 1'b0;
        wait_st(2, 10, "restart_espera");
        check("restart_p1", 32'(p1), 32'(seg(0)));
        check("restart_errou", 32'(err), 32'd0);
        check("restart_col", 32'(cole), 32'(seg(1)));
        check("restart_row", 32'(lin), 32'(seg(0)));

        m1 = 0; m2 = 0;
        for (int i = 0; i < 16; i++) begin
            if (i % 2 == 0) m1++;
            else            m2++;
            sb.push_back(mk(1'b1, 1'b0));
            play(3'((5 * i) % 8), 3'((3 * i + 1) % 8), 1 + (i % 3));
            if (i < 15) wait_st(2, 20, "game_espera");
        end
        wait_st(15, 20, "game_fim");
        check("game_p1", 32'(p1), 32'(seg(8)));
        check("game_p2", 32'(p2), 32'(seg(8)));
        check("sb_left", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
